// File: rtl/dlfloat_div.sv
// DLfloat16 sequential divider (1 sign / 6 exponent, bias 31 / 9 mantissa).
// The mantissa quotient comes from an 11-step restoring divider, one bit per clock.
// Normal operands finish 12 edges after acceptance; specials finish after 1.
module dlfloat_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] c,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StDiv, StNorm} state_e;

  state_e             state_q;
  logic [10:0]        rem_q;
  logic [9:0]         mb_q;
  logic [10:0]        quo_q;
  logic [3:0]         cnt_q;
  logic               sign_q;
  logic signed [7:0]  exp_q;
  logic               special_q;
  logic [15:0]        spec_res_q;

  logic               is_special;
  logic [15:0]        special_res;
  logic signed [7:0]  exp_in;
  logic               rem_ge;
  logic [10:0]        rem_sel;
  logic [10:0]        rem_next;
  logic signed [7:0]  exp_norm;
  logic [8:0]         mant_norm;
  logic [15:0]        norm_res;

  // Operand decode at the accepting edge: specials in priority order, biased exponent difference.
  always_comb begin
    is_special  = 1'b0;
    special_res = 16'h0000;
    if (a == 16'hFFFF || b == 16'hFFFF) begin
      is_special  = 1'b1;
      special_res = 16'hFFFF;
    end else if (b == 16'h0000) begin
      is_special  = 1'b1;
      special_res = 16'hFFFF;
    end else if (a == 16'h0000) begin
      is_special  = 1'b1;
      special_res = 16'h0000;
    end
    // Range is -32..94, so 8 signed bits cannot overflow.
    exp_in = $signed({2'b00, a[14:9]}) - $signed({2'b00, b[14:9]}) + 8'sd31;
  end

  // One restoring step; rem stays below 2*mb so the shift never drops a set bit.
  always_comb begin
    rem_ge   = (rem_q >= {1'b0, mb_q});
    rem_sel  = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
    rem_next = {rem_sel[9:0], 1'b0};
  end

  // Normalise the truncated quotient and clamp the exponent to the encodable range.
  always_comb begin
    if (quo_q[10]) begin
      exp_norm  = exp_q;
      mant_norm = quo_q[9:1];
    end else begin
      exp_norm  = exp_q - 8'sd1;
      mant_norm = quo_q[8:0];
    end
    if (exp_norm > 8'sd63) begin
      norm_res = 16'hFFFF;
    end else if (exp_norm < 8'sd0) begin
      norm_res = 16'h0000;
    end else begin
      norm_res = {sign_q, exp_norm[5:0], mant_norm};
    end
  end

  // Control FSM with registered c/done/busy; start is only honoured in StIdle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      c          <= 16'h0000;
      done       <= 1'b0;
      busy       <= 1'b0;
      rem_q      <= '0;
      mb_q       <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            busy       <= 1'b1;
            sign_q     <= a[15] ^ b[15];
            exp_q      <= exp_in;
            special_q  <= is_special;
            spec_res_q <= special_res;
            mb_q       <= {1'b1, b[8:0]};
            rem_q      <= {2'b01, a[8:0]};
            quo_q      <= '0;
            cnt_q      <= '0;
            state_q    <= is_special ? StNorm : StDiv;
          end
        end
        StDiv: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[9:0], rem_ge};
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd10) begin
            state_q <= StNorm;
          end
        end
        StNorm: begin
          c       <= special_q ? spec_res_q : norm_res;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dlfloat_div.sv
// Self-checking bench for dlfloat_div: directed vector table, random vectors against
// an arithmetic reference model, and hand-written handshake / reset sequences.
module tb_dlfloat_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] c;
  logic        done;
  logic        busy;

  int n_checks;
  int n_fail;
  int cyc;

  dlfloat_div dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c     (c),
    .done  (done),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic [15:0] vc;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: the specification's arithmetic rules with plain integers.
  function automatic logic [15:0] ref_div(input logic [15:0] x, input logic [15:0] y);
    int ea, eb, e, ma, mb, q, mant;
    if (x == 16'hFFFF || y == 16'hFFFF) return 16'hFFFF;
    if (y == 16'h0000) return 16'hFFFF;
    if (x == 16'h0000) return 16'h0000;
    ea = int'(x[14:9]);
    eb = int'(y[14:9]);
    e  = ea - eb + 31;
    ma = 512 + int'(x[8:0]);
    mb = 512 + int'(y[8:0]);
    q  = (ma * 1024) / mb;
    if (q >= 1024) begin
      mant = (q / 2) % 512;
    end else begin
      mant = q % 512;
      e    = e - 1;
    end
    if (e > 63) return 16'hFFFF;
    if (e < 0) return 16'h0000;
    return {x[15] ^ y[15], 6'(e), 9'(mant)};
  endfunction

  function automatic int ref_lat(input logic [15:0] x, input logic [15:0] y);
    if (x == 16'hFFFF || y == 16'hFFFF || y == 16'h0000 || x == 16'h0000) return 1;
    return 12;
  endfunction

  // Issue one divide, measure edges to done, check result, latency and busy.
  task automatic run_div(input string name, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] exp_c, input int exp_lat);
    int n;
    bit seen;
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom();
    b     = $urandom();
    check({name, " busy after accept"}, 16'(busy), 16'd1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no done within 20 edges", name);
    end else begin
      check({name, " c"}, c, exp_c);
      check({name, " latency"}, 16'(n), 16'(exp_lat));
      check({name, " busy at done"}, 16'(busy), 16'd0);
    end
  endtask

  vec_t vecs[$];
  int done_cnt;
  int done_edge;
  int t_prev;
  logic [15:0] ra, rb;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst      = 1'b1;
    start    = 1'b0;
    a        = 16'h0000;
    b        = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset c", c, 16'h0000);
    check("reset done", 16'(done), 16'd0);
    check("reset busy", 16'(busy), 16'd0);
    rst = 1'b0;

    vecs.push_back('{16'h3E00, 16'h3E00, 16'h3E00, 12});
    vecs.push_back('{16'h3E00, 16'h4000, 16'h3C00, 12});
    vecs.push_back('{16'h3E00, 16'h4100, 16'h3AAA, 12});
    vecs.push_back('{16'hC100, 16'h4100, 16'hBE00, 12});
    vecs.push_back('{16'h0000, 16'h4100, 16'h0000, 1});
    vecs.push_back('{16'h4100, 16'h0000, 16'hFFFF, 1});
    vecs.push_back('{16'hFFFF, 16'h0000, 16'hFFFF, 1});
    vecs.push_back('{16'h7FFF, 16'h3C00, 16'hFFFF, 12});
    vecs.push_back('{16'h0200, 16'h4100, 16'h0000, 12});
    vecs.push_back('{16'h0200, 16'h4000, 16'h0000, 12});
    vecs.push_back('{16'h4100, 16'h3E00, 16'h4100, 12});
    for (int i = 0; i < vecs.size(); i++) begin
      run_div($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].lat);
    end

    // Random operands, with occasional specials mixed in.
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom());
      rb = 16'($urandom());
      case ($urandom_range(0, 9))
        0: ra = 16'h0000;
        1: rb = 16'h0000;
        2: ra = 16'hFFFF;
        default: ;
      endcase
      run_div($sformatf("rand%0d %h/%h", i, ra, rb), ra, rb, ref_div(ra, rb), ref_lat(ra, rb));
    end

    // Extra start pulses at edges 3 and 12 must be ignored; busy/done waveform exact.
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = 16'h3E00;
    b     = 16'h4100;
    @(posedge clk);
    #1;
    start    = 1'b0;
    a        = 16'h4100;
    b        = 16'h3E00;
    done_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      start = (k == 3 || k == 12);
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) done_cnt++;
      check($sformatf("hs busy edge%0d", k), 16'(busy), (k < 12) ? 16'd1 : 16'd0);
      check($sformatf("hs done edge%0d", k), 16'(done), (k == 12) ? 16'd1 : 16'd0);
    end
    check("hs done count", 16'(done_cnt), 16'd1);
    check("hs c", c, 16'h3AAA);

    // Back-to-back: start raised as soon as done is seen gives a 13-cycle period.
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = 16'h3E00;
    b     = 16'h4000;
    t_prev = -1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      done_edge = -1;
      for (int n = 0; n < 20 && done_edge < 0; n++) begin
        @(posedge clk);
        #1;
        if (done) done_edge = cyc;
      end
      if (done_edge < 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b2b%0d: no done within 20 edges", i);
      end else begin
        check($sformatf("b2b%0d c", i), c, (i == 1) ? 16'h3E00 : 16'h3C00);
        if (t_prev >= 0) check($sformatf("b2b%0d period", i), 16'(done_edge - t_prev), 16'd13);
        t_prev = done_edge;
      end
      if (i < 2) begin
        start = 1'b1;
        a     = (i == 0) ? 16'h4000 : 16'h3E00;
        b     = (i == 0) ? 16'h4000 : 16'h4000;
      end
    end

    // Reset at edge 5 of a divide discards it with no done pulse.
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = 16'h3E00;
    b     = 16'h4100;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst busy", 16'(busy), 16'd0);
    check("rst c", c, 16'h0000);
    check("rst done", 16'(done), 16'd0);
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check("rst no done", 16'(done_cnt), 16'd0);
    check("rst c held", c, 16'h0000);
    run_div("after rst", 16'h4100, 16'h3E00, 16'h4100, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dlfloat_div.md
# dlfloat_div

Sequential DLfloat16 divider computing c = a / b with a start/done handshake. It is the inverse-direction companion to the pipelined DLfloat16 multiplier in the same datapath and uses the same number format. Format:

- sign = bit 15
- exponent = bits 14:9, bias 31
- mantissa = bits 8:0, with a hidden leading 1

The mantissa quotient is produced by an 11-step restoring divider, one quotient bit per clock, so one divide unit serves a compute lane at low area.

## Interface
- No parameters; the format is fixed at 16 bits (1/6/9).
- clk    input   1   rising-edge clock
- rst    input   1   synchronous, active-high reset
- start  input   1   request; sampled only in IDLE; captures a, b on the same edge
- a      input   16  dividend, DLfloat16
- b      input   16  divisor, DLfloat16
- c      output  16  quotient; registered; holds its value until the next done
- done   output  1   one-cycle pulse; c is valid in the same cycle
- busy   output  1   high from the edge after start is accepted until the edge that raises done

## Operation
- Special operands are decoded at the start edge, in priority order:
  1. a or b == 16'hFFFF (NaN) -> c = 16'hFFFF
  2. b == 16'h0000 -> c = 16'hFFFF
  3. a == 16'h0000 -> c = 16'h0000
- Specials skip the DIV state.
- Sign: s = a[15] ^ b[15].
- Exponent: computed as a signed 8-bit value, e = ea - eb + 31.
- Mantissas: ma = {1, a[8:0]}, mb = {1, b[8:0]} (10 bits each).
- Restoring division:
  - rem is an 11-bit register initialised to ma; q is 11 bits.
  - Each DIV step: if rem >= mb then set the q bit to 1 and rem = rem - mb, else set it to 0. Then rem = rem << 1.
  - Bits are produced MSB first, q[10] down to q[0].
  - Result: q = floor(ma * 1024 / mb), always in the range 512..2047.
- Normalisation, with truncation and no rounding:
  - If q[10] = 1: mant = q[9:1], exp = e.
  - Else: mant = q[8:0], exp = e - 1.
- Range handling:
  - exp > 63 -> c = 16'hFFFF.
  - exp < 0 -> c = 16'h0000.
  - Otherwise c = {s, exp[5:0], mant}.
- State machine: IDLE -> DIV -> NORM -> IDLE.
  - IDLE: if start, latch the operands, the special flag and its result, and e. If special, go to NORM; else load rem and the step counter and go to DIV.
  - DIV: 11 cycles, counter 0..10. After step 10, go to NORM.
  - NORM: register c, pulse done, return to IDLE.
- start while busy, or while in NORM, is ignored and not queued.
- a and b are don't-care except on the accepting edge.

## Timing
- Reset values: c = 16'h0000, done = 0, busy = 0, state = IDLE, counters and remainder cleared.
- Reset mid-operation: rst overrides everything on that edge. The in-flight divide is discarded and no done pulse is produced.
- Normal-operand latency: with the accepting edge counted as edge 0, done and the new c appear after edge 12 (11 DIV edges plus 1 NORM edge). Throughput is 1 result per 13 cycles.
- Special-operand latency: done and c appear after edge 1.
- busy rises after edge 0 and falls after the edge that raises done.
- start in the cycle where done is high is ignored, because the block is in NORM on that edge. The earliest acceptance is the cycle after done.
- done is high for exactly one cycle; c is stable from done until the next done.

## Test plan
- Divide by 1.0: 16'h3E00 / 16'h3E00 -> 16'h3E00 after 12 edges. 16'h3E00 / 16'h4000 (1.0 / 2.0) -> 16'h3C00.
- Normalisation path with q[10] = 0: 16'h3E00 / 16'h4100 (1 / 3) -> 16'h3AAA (q = 682, exp 29). Sign path: 16'hC100 / 16'h4100 -> 16'hBE00.
- Specials, each done after 1 edge:
  - 16'h0000 / 16'h4100 -> 16'h0000
  - 16'h4100 / 16'h0000 -> 16'hFFFF
  - 16'hFFFF / 16'h0000 -> 16'hFFFF
- Range limits:
  - 16'h7FFF / 16'h3C00 -> 16'hFFFF (exp 64)
  - 16'h0200 / 16'h4100 -> 16'h0000 (exp -1)
  - 16'h0200 / 16'h4000 -> 16'h0000 (exp 0, mantissa 0)
- Handshake:
  - Pulse start again at edges 3 and 12 -> ignored; exactly one done.
  - Back-to-back requests started the cycle after each done -> 1 result per 13 cycles.
  - busy and done waveforms exact.
- Reset: assert rst at edge 5 of a divide -> busy = 0, c = 16'h0000, no done pulse. A start after rst deasserts completes normally.
